// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl
//   Sequencer in front of the matmul datapath. A host start streams k_len operand
//   beats from the activation SRAM (DIN_W per beat) and the weight SRAM (WIN_W per
//   beat) into matmul. The last beat is flagged on mm_valid_o. The block then waits
//   for the matmul result and holds it on a valid/ready output until consumed.
//   Only one job is in flight at a time.
//
// Ports
//   clk_i, rstn_i                 clock (rising edge), asynchronous active-low reset
//   start_i, k_len_i              job request and beat count, sampled when accepted in IDLE
//   a_base_i, w_base_i            SRAM base addresses, sampled when accepted
//   busy_o                        high while a job is active (state != IDLE)
//   done_o                        1-cycle pulse at job end, on both normal and error completion
//   err_o                         sticky error (k_len=0 or result timeout), cleared on the next accepted job
//   act_rd_o/act_addr_o/act_data_i  activation SRAM port (read data arrives 1 cycle after the strobe)
//   wgt_rd_o/wgt_addr_o/wgt_data_i  weight SRAM port (same timing as activation)
//   mm_en_o/mm_valid_o/mm_din_o/mm_win_o  beat stream into matmul
//   mm_vld_i/mm_res_i             matmul result handshake
//   res_o/res_vld_o/res_rdy_i     captured result, valid/ready
module matmul_seq_ctrl #(
  parameter int DIN_W   = 128,
  parameter int WIN_W   = 8,
  parameter int RES_W   = 512,
  parameter int ADDR_W  = 8,
  parameter int KLEN_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [KLEN_W-1:0] k_len_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              act_rd_o,
  output logic [ADDR_W-1:0] act_addr_o,
  input  logic [DIN_W-1:0]  act_data_i,
  output logic              wgt_rd_o,
  output logic [ADDR_W-1:0] wgt_addr_o,
  input  logic [WIN_W-1:0]  wgt_data_i,
  output logic              mm_en_o,
  output logic              mm_valid_o,
  output logic [DIN_W-1:0]  mm_din_o,
  output logic [WIN_W-1:0]  mm_win_o,
  input  logic              mm_vld_i,
  input  logic [RES_W-1:0]  mm_res_i,
  output logic [RES_W-1:0]  res_o,
  output logic              res_vld_o,
  input  logic              res_rdy_i
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_WAIT_RES,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [KLEN_W-1:0]   idx_q, idx_d;
  logic [KLEN_W-1:0]   klen_q, klen_d;
  logic [ADDR_W-1:0]   a_base_q, a_base_d;
  logic [ADDR_W-1:0]   w_base_q, w_base_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                res_vld_q, res_vld_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic                mm_en_q, mm_valid_q;
  logic                rd;
  logic                last_rd;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    klen_d    = klen_q;
    a_base_d  = a_base_q;
    w_base_d  = w_base_q;
    tmr_d     = tmr_q;
    err_d     = err_q;
    done_d    = 1'b0;
    res_vld_d = res_vld_q;
    res_d     = res_q;
    rd        = 1'b0;
    last_rd   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (k_len_i != '0) begin
            klen_d   = k_len_i;
            a_base_d = a_base_i;
            w_base_d = w_base_i;
            idx_d    = '0;
            err_d    = 1'b0;
            state_d  = S_STREAM;
          end else begin
            // Empty job: flag it and finish without touching the SRAMs.
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        rd    = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == klen_q - 1'b1) begin
          last_rd = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last beat is on the matmul inputs this cycle.
        tmr_d   = '0;
        state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        // A result arriving on the final timer cycle still wins over the timeout.
        if (mm_vld_i) begin
          res_d     = mm_res_i;
          res_vld_d = 1'b1;
          state_d   = S_OUT;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_OUT: begin
        if (res_rdy_i) begin
          res_vld_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      klen_q     <= '0;
      a_base_q   <= '0;
      w_base_q   <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_q      <= '0;
      mm_en_q    <= 1'b0;
      mm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      klen_q     <= klen_d;
      a_base_q   <= a_base_d;
      w_base_q   <= w_base_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
      done_q     <= done_d;
      res_vld_q  <= res_vld_d;
      res_q      <= res_d;
      // SRAM read latency is one cycle, so the beat qualifiers trail the strobe by one.
      mm_en_q    <= rd;
      mm_valid_q <= last_rd;
    end
  end

  // Addresses are driven only while reading, and wrap modulo 2^ADDR_W.
  assign act_rd_o   = rd;
  assign wgt_rd_o   = rd;
  assign act_addr_o = rd ? a_base_q + ADDR_W'(idx_q) : '0;
  assign wgt_addr_o = rd ? w_base_q + ADDR_W'(idx_q) : '0;

  assign mm_en_o    = mm_en_q;
  assign mm_valid_o = mm_valid_q;
  assign mm_din_o   = mm_en_q ? act_data_i : '0;
  assign mm_win_o   = mm_en_q ? wgt_data_i : '0;

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign res_o     = res_q;
  assign res_vld_o = res_vld_q;

endmodule
